// File: rtl/gol_window_feeder.sv
// Raster-stream window feeder for the game-of-life cell: turns a serial
// board image into (centre, 8-neighbour) words with zero padding at the edges.
`timescale 1ns/1ps
module gol_window_feeder #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  parameter int XW     = $clog2(WIDTH),
  parameter int YW     = $clog2(HEIGHT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_cell,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_neighbors,
  output logic          out_center,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic          out_last
);

  // The window spans 2*WIDTH+3 samples; the newest one is the incoming
  // sample itself, so only 2*WIDTH+2 need to be stored.
  localparam int HL   = 2*WIDTH + 2;
  localparam int NPIX = WIDTH*HEIGHT;
  localparam int CW   = $clog2(NPIX + 1);

  localparam logic [1:0] S_FILL  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]    state;
  logic [HL-1:0] hist;      // hist[0] = most recent stored sample
  logic [CW-1:0] cnt;       // sample index in FILL/RUN, flush step in FLUSH
  logic [XW-1:0] nx;        // coordinate of the next word to load
  logic [YW-1:0] ny;

  logic       advance, accept, step, load, samp, at_l, at_r;
  logic [7:0] nb;

  // Handshake, sample source and window tap selection
  always_comb begin
    advance  = !out_valid || out_ready;
    in_ready = 1'b0;
    case (state)
      S_FILL:  in_ready = 1'b1;
      S_RUN:   in_ready = advance;
      default: in_ready = 1'b0;
    endcase
    accept = in_valid && in_ready;
    step   = accept || (state == S_FLUSH && advance);
    load   = (state == S_RUN && accept) || (state == S_FLUSH && advance);
    samp   = (state == S_FLUSH) ? 1'b0 : in_cell;
    at_l   = (nx == '0);
    at_r   = (nx == XW'(WIDTH-1));
    // Centre sits WIDTH+1 samples behind the incoming one.
    nb[0]  = hist[2*WIDTH+1] & !at_l;   // NW
    nb[1]  = hist[2*WIDTH];             // N
    nb[2]  = hist[2*WIDTH-1] & !at_r;   // NE
    nb[3]  = hist[WIDTH+1]   & !at_l;   // W
    nb[4]  = hist[WIDTH-1]   & !at_r;   // E
    nb[5]  = hist[1]         & !at_l;   // SW
    nb[6]  = hist[0];                   // S
    nb[7]  = samp            & !at_r;   // SE
  end

  // Frame sequencing: FILL primes the line buffers, RUN streams, FLUSH
  // pushes zeros to complete the last row, then history is wiped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FILL;
      hist  <= '0;
      cnt   <= '0;
    end else if (clear) begin
      state <= S_FILL;
      hist  <= '0;
      cnt   <= '0;
    end else begin
      if (step) hist <= {hist[HL-2:0], samp};
      case (state)
        S_FILL: if (accept) begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH)) state <= S_RUN;
        end
        S_RUN: if (accept) begin
          if (cnt == CW'(NPIX-1)) begin
            state <= S_FLUSH;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: if (advance) begin
          if (cnt == CW'(WIDTH)) begin
            state <= S_FILL;
            cnt   <= '0;
            hist  <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Output word register with raster coordinate tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_neighbors <= '0;
      out_center    <= 1'b0;
      out_x         <= '0;
      out_y         <= '0;
      out_last      <= 1'b0;
      nx            <= '0;
      ny            <= '0;
    end else if (clear) begin
      out_valid     <= 1'b0;
      out_neighbors <= '0;
      out_center    <= 1'b0;
      out_x         <= '0;
      out_y         <= '0;
      out_last      <= 1'b0;
      nx            <= '0;
      ny            <= '0;
    end else if (load) begin
      out_valid     <= 1'b1;
      out_neighbors <= nb;
      out_center    <= hist[WIDTH];
      out_x         <= nx;
      out_y         <= ny;
      out_last      <= at_r && (ny == YW'(HEIGHT-1));
      if (at_r) begin
        nx <= '0;
        ny <= (ny == YW'(HEIGHT-1)) ? '0 : ny + YW'(1);
      end else begin
        nx <= nx + XW'(1);
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gol_window_feeder.sv
// Directed bench for gol_window_feeder on a 4x4 board.
`timescale 1ns/1ps
module tb_gol_window_feeder;
  logic       clk = 0, rst_n = 0, clear = 0, in_valid = 0, in_cell = 0, out_ready = 1;
  logic       in_ready, out_valid, out_center, out_last;
  logic [7:0] out_neighbors;
  logic [1:0] out_x, out_y;

  int passed = 0, total = 0;
  int n = 0;
  logic [7:0] nb_q [0:255];
  int         pos_q[0:255];

  gol_window_feeder #(.WIDTH(4), .HEIGHT(4)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_cell(in_cell), .out_valid(out_valid), .out_ready(out_ready),
    .out_neighbors(out_neighbors), .out_center(out_center), .out_x(out_x),
    .out_y(out_y), .out_last(out_last));

  always #5 clk = ~clk;

  // Record every word the consumer takes on the coming edge
  always @(negedge clk) begin
    if (rst_n && !clear && out_valid && out_ready && n < 256) begin
      nb_q[n]  = out_neighbors;
      pos_q[n] = int'({out_y, out_x, out_last, out_center});
      n = n + 1;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Independent reference: look up the board with explicit bounds checks
  function automatic logic [7:0] exp_nb(input logic [15:0] b, input int y, input int x);
    logic [7:0] r;
    int dy, dx;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      dy = (k < 3) ? -1 : (k < 5) ? 0 : 1;
      dx = (k == 0 || k == 3 || k == 5) ? -1 : (k == 1 || k == 6) ? 0 : 1;
      if (y+dy >= 0 && y+dy < 4 && x+dx >= 0 && x+dx < 4) r[k] = b[(y+dy)*4 + x+dx];
    end
    return r;
  endfunction

  task automatic send(input logic b, output int tries);
    logic acc;
    in_cell = b; in_valid = 1; tries = 0;
    do begin
      acc = in_ready;
      tries++;
      @(posedge clk); #1;
    end while (!acc && tries < 50);
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_flush(output int low);
    in_valid = 0; low = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) break;
      low++;
    end
  endtask

  task automatic check_frame(input logic [15:0] b, input int base);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("nb[%0d]", i), nb_q[base+i], exp_nb(b, i/4, i%4));
      chk($sformatf("pos[%0d]", i), pos_q[base+i],
          (i/4)*16 + (i%4)*4 + ((i == 15) ? 2 : 0) + b[i]);
    end
  endtask

  initial begin
    logic [15:0] ones, zeros, single;
    int t, low, b1, b2, b3;
    ones = 16'hFFFF; zeros = 16'h0000; single = 16'h0020;

    // Reset state
    #3;
    chk("rst_valid", out_valid, 0);
    chk("rst_nb", out_neighbors, 0);
    chk("rst_pos", {out_y, out_x, out_last, out_center}, 0);
    chk("rst_ready", in_ready, 1);
    #4 rst_n = 1;
    @(posedge clk); #1;

    // All-ones frame with free-flowing output
    b1 = n;
    for (int i = 0; i < 16; i++) begin
      send(ones[i], t);
      if (i == 4) chk("valid_before_w1", out_valid, 0);
      if (i == 5) chk("valid_after_w1", out_valid, 1);
    end
    wait_flush(low);
    chk("flush_low_cycles", low, 5);

    // Back-to-back all-zeros frame, first pixel accepted right away
    b2 = b1 + 16;
    for (int i = 0; i < 16; i++) begin
      send(zeros[i], t);
      if (i == 0) chk("b2b_first_try", t, 1);
    end
    wait_flush(low);
    repeat (2) @(negedge clk);
    chk("two_frame_count", n - b1, 32);
    chk("ones_00", nb_q[b1+0], 8'hD0);
    chk("ones_01", nb_q[b1+1], 8'hF8);
    chk("ones_11", nb_q[b1+5], 8'hFF);
    chk("ones_33", nb_q[b1+15], 8'h0B);
    chk("ones_33_last", pos_q[b1+15] & 2, 2);
    check_frame(ones, b1);
    chk("zeros_00", nb_q[b2+0], 8'h00);
    check_frame(zeros, b2);

    // Single live cell at (1,1) with 3 cycles of backpressure mid-frame
    b3 = n;
    for (int i = 0; i < 16; i++) begin
      send(single[i], t);
      if (i == 8) begin
        in_cell = single[9];
        out_ready = 0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("bp_in_ready", in_ready, 0);
          chk("bp_valid", out_valid, 1);
          chk("bp_hold_nb", out_neighbors, exp_nb(single, 0, 3));
          chk("bp_hold_pos", {out_y, out_x}, 4'b0011);
        end
        @(posedge clk); #1;
        out_ready = 1;
      end
    end
    wait_flush(low);
    repeat (2) @(negedge clk);
    chk("bp_count", n - b3, 16);
    chk("single_00", nb_q[b3+0], 8'h80);
    chk("single_11", nb_q[b3+5], 8'h00);
    chk("single_11_c", pos_q[b3+5] & 1, 1);
    chk("single_22", nb_q[b3+10], 8'h01);
    chk("single_10", nb_q[b3+4], 8'h10);
    chk("single_13", nb_q[b3+7], 8'h00);
    check_frame(single, b3);

    // Abort with clear after 7 pixels, then a full frame
    @(posedge clk); #1;
    for (int i = 0; i < 7; i++) send(1'b1, t);
    in_valid = 1; in_cell = 1; clear = 1;
    @(posedge clk); #1;
    clear = 0; in_valid = 0;
    chk("clear_valid", out_valid, 0);
    chk("clear_ready", in_ready, 1);
    b1 = n;
    for (int i = 0; i < 16; i++) send(ones[i], t);
    wait_flush(low);
    repeat (2) @(negedge clk);
    chk("clear_count", n - b1, 16);
    chk("clear_first_pos", pos_q[b1] & 8'hFC, 0);
    check_frame(ones, b1);

    // Asynchronous reset between edges while a word is pending
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) send(1'b1, t);
    in_valid = 0;
    chk("pre_rst_valid", out_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_nb", out_neighbors, 0);
    chk("arst_pos", {out_y, out_x, out_last, out_center}, 0);
    #3 rst_n = 1;
    @(negedge clk);
    chk("arst_ready", in_ready, 1);
    b1 = n;
    for (int i = 0; i < 16; i++) send(single[i], t);
    wait_flush(low);
    repeat (2) @(negedge clk);
    chk("arst_count", n - b1, 16);
    check_frame(single, b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
